// File: rtl/sam_pkg.sv
// Shared definitions for the SAM control unit: FSM state encoding and the
// bit positions of the 22-bit datapath control word.
package sam_pkg;

    // Controller states: reset, fetch, then one short sequence per opcode.
    typedef enum logic [3:0] {
        S_RST = 4'd0,
        S_F1  = 4'd1,
        S_F2  = 4'd2,
        S_F3  = 4'd3,
        S_F4  = 4'd4,
        S_LD1 = 4'd5,
        S_LD2 = 4'd6,
        S_LD3 = 4'd7,
        S_LD4 = 4'd8,
        S_ST1 = 4'd9,
        S_ST2 = 4'd10,
        S_AD1 = 4'd11,
        S_AD2 = 4'd12,
        S_AD3 = 4'd13,
        S_AD4 = 4'd14,
        S_BR1 = 4'd15
    } state_t;

    // Opcode field {ir15, ir14}.
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_BRN   = 2'b11;

    // Control word bit positions.
    localparam int B_PC_ABUS    = 21;
    localparam int B_IR_ABUS    = 20;
    localparam int B_MBR_ABUS   = 19;
    localparam int B_RBUS_AC    = 18;
    localparam int B_AC_ALUA    = 17;
    localparam int B_MBUS_ALUB  = 16;
    localparam int B_ALU_ADD    = 15;
    localparam int B_ALU_PASSB  = 14;
    localparam int B_MAR_ADDR   = 13;
    localparam int B_MBR_DATA   = 12;
    localparam int B_ABUS_IR    = 11;
    localparam int B_ABUS_MAR   = 10;
    localparam int B_DATA_MBR   = 9;
    localparam int B_RBUS_MBR   = 8;
    localparam int B_MBR_MBUS   = 7;
    localparam int B_PC_CLR     = 6;
    localparam int B_PC_INC2    = 5;
    localparam int B_ABUS_PC    = 4;
    localparam int B_RW         = 3;
    localparam int B_REQUEST    = 2;
    localparam int B_AC_RBUS    = 1;
    localparam int B_ALU_RBUS   = 0;

endpackage

// File: rtl/sam_controller.sv
// SAM control unit: Moore FSM sequencing fetch and LOAD/STORE/ADD/BRN
// execution. The control word b is decoded purely from the current state.
// Memory handshake: in an access state REQUEST (and RW) stay asserted and the
// state holds while mem_wait=1; the first cycle seen with mem_wait=0 completes
// the access and the FSM advances on the next edge.
module sam_controller
    import sam_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_wait,
    input  logic        ir15,
    input  logic        ac15,
    input  logic        ir14,
    output logic [21:0] b
);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] opcode;

    assign opcode = {ir15, ir14};

    // State register; reset overrides everything, including an access in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; opcode/ac15 only matter in F4, mem_wait only in access states.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RST: state_d = S_F1;
            S_F1:  state_d = S_F2;
            S_F2:  state_d = mem_wait ? S_F2 : S_F3;
            S_F3:  state_d = S_F4;
            S_F4: begin
                unique case (opcode)
                    OP_LOAD:  state_d = S_LD1;
                    OP_STORE: state_d = S_ST1;
                    OP_ADD:   state_d = S_AD1;
                    OP_BRN:   state_d = ac15 ? S_BR1 : S_F1;
                    default:  state_d = S_F1;
                endcase
            end
            S_LD1: state_d = S_LD2;
            S_LD2: state_d = mem_wait ? S_LD2 : S_LD3;
            S_LD3: state_d = S_LD4;
            S_LD4: state_d = S_F1;
            S_ST1: state_d = S_ST2;
            S_ST2: state_d = mem_wait ? S_ST2 : S_F1;
            S_AD1: state_d = S_AD2;
            S_AD2: state_d = mem_wait ? S_AD2 : S_AD3;
            S_AD3: state_d = S_AD4;
            S_AD4: state_d = S_F1;
            S_BR1: state_d = S_F1;
            default: state_d = S_RST;
        endcase
    end

    // Control word decode; every bit not named for a state stays 0.
    always_comb begin
        b = '0;
        unique case (state_q)
            S_RST: b[B_PC_CLR] = 1'b1;
            S_F1: begin
                b[B_PC_ABUS]  = 1'b1;
                b[B_ABUS_MAR] = 1'b1;
                b[B_PC_INC2]  = 1'b1;
            end
            S_F2, S_LD2, S_AD2: begin
                b[B_MAR_ADDR] = 1'b1;
                b[B_RW]       = 1'b1;
                b[B_REQUEST]  = 1'b1;
            end
            S_F3, S_LD3, S_AD3: b[B_DATA_MBR] = 1'b1;
            S_F4: begin
                b[B_MBR_ABUS] = 1'b1;
                b[B_ABUS_IR]  = 1'b1;
            end
            S_LD1, S_AD1: begin
                b[B_IR_ABUS]  = 1'b1;
                b[B_ABUS_MAR] = 1'b1;
            end
            S_LD4: begin
                b[B_MBR_MBUS]  = 1'b1;
                b[B_MBUS_ALUB] = 1'b1;
                b[B_ALU_PASSB] = 1'b1;
                b[B_ALU_RBUS]  = 1'b1;
                b[B_RBUS_AC]   = 1'b1;
            end
            S_ST1: begin
                b[B_IR_ABUS]  = 1'b1;
                b[B_ABUS_MAR] = 1'b1;
                b[B_AC_RBUS]  = 1'b1;
                b[B_RBUS_MBR] = 1'b1;
            end
            // Write access: RW deliberately left at 0.
            S_ST2: begin
                b[B_MAR_ADDR] = 1'b1;
                b[B_MBR_DATA] = 1'b1;
                b[B_REQUEST]  = 1'b1;
            end
            S_AD4: begin
                b[B_AC_ALUA]   = 1'b1;
                b[B_MBR_MBUS]  = 1'b1;
                b[B_MBUS_ALUB] = 1'b1;
                b[B_ALU_ADD]   = 1'b1;
                b[B_ALU_RBUS]  = 1'b1;
                b[B_RBUS_AC]   = 1'b1;
            end
            S_BR1: begin
                b[B_IR_ABUS] = 1'b1;
                b[B_ABUS_PC] = 1'b1;
            end
            default: b = '0;
        endcase
    end

endmodule

// File: tb/tb_sam_controller.sv
// Testbench for sam_controller. The driver walks whole instructions, pushing
// the control word expected in each cycle; a monitor on the falling edge pops
// and compares. Inputs that must be ignored are randomised.
module tb_sam_controller;

    logic        clk;
    logic        reset;
    logic        mem_wait;
    logic        ir15;
    logic        ac15;
    logic        ir14;
    logic [21:0] b;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic [21:0] exp_q[$];

    // Expected control words, built from the datapath bit meanings.
    localparam logic [21:0] W_RST = 22'h000040;
    localparam logic [21:0] W_F1  = 22'h200420;
    localparam logic [21:0] W_RD  = 22'h00200C;   // F2 / LD2 / AD2
    localparam logic [21:0] W_F3  = 22'h000200;   // F3 / LD3 / AD3
    localparam logic [21:0] W_F4  = 22'h080800;
    localparam logic [21:0] W_X1  = 22'h100400;   // LD1 / AD1
    localparam logic [21:0] W_LD4 = 22'h054081;   // bits 18,16,14,7,0
    localparam logic [21:0] W_ST1 = 22'h100502;
    localparam logic [21:0] W_ST2 = 22'h003004;
    localparam logic [21:0] W_AD4 = 22'h078081;   // bits 18,17,16,15,7,0
    localparam logic [21:0] W_BR1 = 22'h100010;

    sam_controller dut (
        .clk      (clk),
        .reset    (reset),
        .mem_wait (mem_wait),
        .ir15     (ir15),
        .ac15     (ac15),
        .ir14     (ir14),
        .b        (b)
    );

    // Clock and initial input values.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: one comparison per cycle while enabled.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL queue_empty: b=%h with no expected word", b);
            end else begin
                logic [21:0] e;
                e = exp_q.pop_front();
                if (b !== e) begin
                    errors++;
                    $display("FAIL ctrl_word @%0t: b=%h expected %h", $time, b, e);
                end
            end
        end
    end

    // One clock cycle: called just after a rising edge; pushes the word the DUT
    // should show now and drives inputs for the coming edge.
    task automatic cyc(input logic [21:0] exp_b, input logic mw, input logic is_f4,
                       input logic [1:0] op, input logic ac, input logic rst);
        exp_q.push_back(exp_b);
        mem_wait = mw;
        reset    = rst;
        if (is_f4) begin
            {ir15, ir14} = op;
            ac15 = ac;
        end else begin
            {ir15, ir14} = 2'($urandom_range(0, 3));
            ac15 = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
    endtask

    // Plain state: mem_wait, opcode and ac15 are don't-cares.
    task automatic plain(input logic [21:0] exp_b);
        cyc(exp_b, 1'($urandom_range(0, 1)), 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    // Memory access: holds the same word for w wait cycles plus the final one.
    task automatic mem_access(input logic [21:0] exp_b, input int w);
        for (int i = 0; i < w; i++) cyc(exp_b, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        cyc(exp_b, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    // A complete instruction starting in F1.
    task automatic run_instr(input logic [1:0] op, input logic ac, input int wf, input int we);
        plain(W_F1);
        mem_access(W_RD, wf);
        plain(W_F3);
        cyc(W_F4, 1'($urandom_range(0, 1)), 1'b1, op, ac, 1'b0);
        case (op)
            2'b00: begin
                plain(W_X1);
                mem_access(W_RD, we);
                plain(W_F3);
                plain(W_LD4);
            end
            2'b01: begin
                plain(W_ST1);
                mem_access(W_ST2, we);
            end
            2'b10: begin
                plain(W_X1);
                mem_access(W_RD, we);
                plain(W_F3);
                plain(W_AD4);
            end
            default: begin
                if (ac) plain(W_BR1);
            end
        endcase
    endtask

    // Stimulus sequence.
    initial begin
        reset    = 1'b1;
        mem_wait = 1'b0;
        ir15     = 1'b0;
        ir14     = 1'b0;
        ac15     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset held, then released; next word must be F1.
        cyc(W_RST, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        cyc(W_RST, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        // Directed: LOAD with 3-cycle fetch wait, STORE, BRN taken / not taken, ADD.
        run_instr(2'b00, 1'b0, 3, 0);
        run_instr(2'b01, 1'b1, 0, 0);
        run_instr(2'b11, 1'b1, 0, 0);
        run_instr(2'b11, 1'b0, 0, 0);
        run_instr(2'b10, 1'b0, 0, 0);
        run_instr(2'b01, 1'b0, 1, 2);

        // Reset during LD2 while memory is still busy.
        plain(W_F1);
        mem_access(W_RD, 0);
        plain(W_F3);
        cyc(W_F4, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        plain(W_X1);
        cyc(W_RD, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        cyc(W_RD, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        cyc(W_RST, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);

        // Randomised instruction stream with random wait lengths.
        for (int n = 0; n < 300; n++) begin
            run_instr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
            if ($urandom_range(0, 19) == 0) begin
                cyc(W_F1, 1'($urandom_range(0, 1)), 1'b0, 2'b00, 1'b0, 1'b1);
                cyc(W_RST, 1'($urandom_range(0, 1)), 1'b0, 2'b00, 1'b0, 1'b0);
            end
        end

        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d expected words left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
